// File: rtl/flags_unit.sv
// flags_unit -- condition-flag register with issue/writeback tracking.
//
// Holds the architectural [Z, C, N, V] flags and updates them when a
// flag-setting instruction retires at writeback. A small counter tracks
// flag-setting instructions that have issued but not yet written back, so
// downstream logic knows when the flags are stable.
//
// Ports:
//   clk              clock, rising-edge active
//   rst_n            asynchronous active-low reset
//   issue_set_flags  a flag-setting instruction is issuing this cycle
//   issue_ready      a flag-setting issue can be accepted (pending < 3)
//   alu_valid        ALU result present at writeback
//   alu_set_flags    writeback instruction updates flags
//   alu_op           00 logical, 01 add, 10 sub, 11 flags write
//   alu_a, alu_b     ALU operands
//   alu_result       ALU result (logical ops only)
//   shifter_carry    shifter carry-out (logical ops only)
//   flags            registered {Z, C, N, V}
//   flags_valid      no flag-setting instruction outstanding
//   proto_err        sticky: writeback arrived with nothing outstanding
module flags_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        issue_set_flags,
   output logic        issue_ready,
   input  logic        alu_valid,
   input  logic        alu_set_flags,
   input  logic [1:0]  alu_op,
   input  logic [31:0] alu_a,
   input  logic [31:0] alu_b,
   input  logic [31:0] alu_result,
   input  logic        shifter_carry,
   output logic [3:0]  flags,
   output logic        flags_valid,
   output logic        proto_err
);

   localparam logic [1:0] OpLogic = 2'b00;
   localparam logic [1:0] OpAdd   = 2'b01;
   localparam logic [1:0] OpSub   = 2'b10;
   localparam logic [1:0] OpWrite = 2'b11;

   // Bit positions inside flags; the branch checker expects {Z, C, N, V}.
   localparam int unsigned FlagV = 0;

   logic [1:0]  pending_q, pending_d;
   logic [3:0]  flags_q, flags_d;
   logic        proto_err_q, proto_err_d;

   logic        accept;
   logic        retire;
   logic [32:0] sum;
   logic [32:0] diff;

   assign issue_ready = (pending_q != 2'd3);
   assign accept      = issue_set_flags && issue_ready;
   assign retire      = alu_valid && alu_set_flags;

   assign sum  = {1'b0, alu_a} + {1'b0, alu_b};
   assign diff = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;

   // Next-state flags
   always_comb begin
      flags_d = flags_q;
      if (retire) begin
         unique case (alu_op)
            OpLogic: flags_d = {(alu_result == 32'd0), shifter_carry, alu_result[31],
                                flags_q[FlagV]};
            OpAdd:   flags_d = {(sum[31:0] == 32'd0), sum[32], sum[31],
                                (alu_a[31] == alu_b[31]) && (sum[31] != alu_a[31])};
            OpSub:   flags_d = {(diff[31:0] == 32'd0), diff[32], diff[31],
                                (alu_a[31] != alu_b[31]) && (diff[31] != alu_a[31])};
            OpWrite: flags_d = {alu_b[30], alu_b[29], alu_b[31], alu_b[28]};
            default: flags_d = flags_q;
         endcase
      end
   end

   // Pending counter and protocol error
   always_comb begin
      pending_d   = pending_q;
      proto_err_d = proto_err_q;
      unique case ({accept, retire})
         2'b10: pending_d = pending_q + 2'd1;
         2'b01: begin
            if (pending_q == 2'd0) begin
               // Orphan writeback: counter stays at zero, error is latched.
               proto_err_d = 1'b1;
            end else begin
               pending_d = pending_q - 2'd1;
            end
         end
         default: pending_d = pending_q; // idle, or issue and retire cancel out
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q   <= 2'd0;
         flags_q     <= 4'b0000;
         proto_err_q <= 1'b0;
      end else begin
         pending_q   <= pending_d;
         flags_q     <= flags_d;
         proto_err_q <= proto_err_d;
      end
   end

   assign flags       = flags_q;
   assign flags_valid = (pending_q == 2'd0);
   assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_flags_unit.sv
// Directed bench for flags_unit. Expected flag values are pushed to a
// scoreboard queue when a retire is driven and popped after the edge.
module tb_flags_unit;

   logic        clk;
   logic        rst_n;
   logic        issue_set_flags;
   logic        issue_ready;
   logic        alu_valid;
   logic        alu_set_flags;
   logic [1:0]  alu_op;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_result;
   logic        shifter_carry;
   logic [3:0]  flags;
   logic        flags_valid;
   logic        proto_err;

   int unsigned vectors;
   int unsigned miscompares;

   logic [3:0]  sb_flags[$];
   string       sb_tag[$];

   flags_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .issue_set_flags (issue_set_flags),
      .issue_ready     (issue_ready),
      .alu_valid       (alu_valid),
      .alu_set_flags   (alu_set_flags),
      .alu_op          (alu_op),
      .alu_a           (alu_a),
      .alu_b           (alu_b),
      .alu_result      (alu_result),
      .shifter_carry   (shifter_carry),
      .flags           (flags),
      .flags_valid     (flags_valid),
      .proto_err       (proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      issue_set_flags = 1'b0;
      alu_valid       = 1'b0;
      alu_set_flags   = 1'b0;
      alu_op          = 2'b00;
      alu_a           = 32'd0;
      alu_b           = 32'd0;
      alu_result      = 32'd0;
      shifter_carry   = 1'b0;
   endtask

   // Advance one clock, leaving the bench 1 time unit past the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue_only();
      idle_inputs();
      issue_set_flags = 1'b1;
      tick();
      idle_inputs();
   endtask

   // Drive a flag-setting writeback (optionally with an issue in the same
   // cycle), push the expected flags, then pop and compare after the edge.
   task automatic retire(input string tag, input logic issue, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] res, input logic sc,
                         input logic [3:0] exp_flags);
      logic [3:0] exp;
      string      t;
      idle_inputs();
      issue_set_flags = issue;
      alu_valid       = 1'b1;
      alu_set_flags   = 1'b1;
      alu_op          = op;
      alu_a           = a;
      alu_b           = b;
      alu_result      = res;
      shifter_carry   = sc;
      sb_flags.push_back(exp_flags);
      sb_tag.push_back(tag);
      tick();
      idle_inputs();
      if (sb_flags.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
      end else begin
         exp = sb_flags.pop_front();
         t   = sb_tag.pop_front();
         check(t, flags, exp);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      idle_inputs();
      rst_n = 1'b0;
      #3;
      check("rst_flags", flags, 4'b0000);
      check("rst_valid", {3'b0, flags_valid}, 4'd1);
      check("rst_ready", {3'b0, issue_ready}, 4'd1);
      check("rst_perr",  {3'b0, proto_err}, 4'd0);
      #19 rst_n = 1'b1;   // release between edges
      #4;

      // sub 5-5 retired with one outstanding: Z=1 C=1 N=0 V=0
      issue_only();
      check("pend1_valid", {3'b0, flags_valid}, 4'd0);
      retire("sub_5_5", 1'b0, 2'b10, 32'd5, 32'd5, 32'd0, 1'b0, 4'b1100);
      check("sub_5_5_valid", {3'b0, flags_valid}, 4'd1);
      check("sub_5_5_perr",  {3'b0, proto_err}, 4'd0);

      // Issue and retire together at pending 0: count stays 0, no error
      retire("add_ovf", 1'b1, 2'b01, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 4'b0011);
      check("add_ovf_valid", {3'b0, flags_valid}, 4'd1);
      check("add_ovf_perr",  {3'b0, proto_err}, 4'd0);

      issue_only();
      retire("add_carry", 1'b0, 2'b01, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 4'b1100);
      issue_only();
      retire("sub_3_5", 1'b0, 2'b10, 32'd3, 32'd5, 32'd0, 1'b0, 4'b0010);
      issue_only();
      retire("logic_zero", 1'b0, 2'b00, 32'd0, 32'd0, 32'd0, 1'b1, 4'b1100);

      // Logical op must hold a set V
      issue_only();
      retire("add_ovf2", 1'b0, 2'b01, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 4'b0011);
      issue_only();
      retire("logic_vhold", 1'b0, 2'b00, 32'd0, 32'd0, 32'h8000_0000, 1'b0, 4'b0011);

      // alu_valid without S bit changes nothing
      idle_inputs();
      alu_valid = 1'b1;
      alu_op    = 2'b11;
      alu_b     = 32'hF000_0000;
      tick();
      idle_inputs();
      check("nos_flags", flags, 4'b0011);
      check("nos_valid", {3'b0, flags_valid}, 4'd1);
      check("nos_perr",  {3'b0, proto_err}, 4'd0);

      // Fill the pending counter; fourth issue must not wrap
      issue_only();
      check("fill1_ready", {3'b0, issue_ready}, 4'd1);
      issue_only();
      check("fill2_ready", {3'b0, issue_ready}, 4'd1);
      issue_only();
      check("fill3_ready", {3'b0, issue_ready}, 4'd0);
      issue_only();
      check("fill4_ready", {3'b0, issue_ready}, 4'd0);
      check("fill4_valid", {3'b0, flags_valid}, 4'd0);

      // At pending 3 an issue cannot be accepted, so a plain retire drops
      // to 2; issue+retire together then holds the count at 2.
      retire("wr_a0", 1'b0, 2'b11, 32'd0, 32'hA000_0000, 32'd0, 1'b0, 4'b0110);
      check("p2_ready", {3'b0, issue_ready}, 4'd1);
      retire("both_p2", 1'b1, 2'b00, 32'd0, 32'd0, 32'd1, 1'b0, 4'b0000);
      check("both_p2_ready", {3'b0, issue_ready}, 4'd1);
      issue_only();
      check("p3_again_ready", {3'b0, issue_ready}, 4'd0);

      retire("wr_00", 1'b0, 2'b11, 32'd0, 32'h0000_0000, 32'd0, 1'b0, 4'b0000);
      retire("wr_f0", 1'b0, 2'b11, 32'd0, 32'hF000_0000, 32'd0, 1'b0, 4'b1111);
      check("drain_valid_n", {3'b0, flags_valid}, 4'd0);
      retire("wr_50", 1'b0, 2'b11, 32'd0, 32'h5000_0000, 32'd0, 1'b0, 4'b1001);
      check("drain_valid", {3'b0, flags_valid}, 4'd1);
      check("drain_perr",  {3'b0, proto_err}, 4'd0);

      // Orphan retire: error set, flags still update, count stays 0
      retire("orphan", 1'b0, 2'b10, 32'd5, 32'd3, 32'd0, 1'b0, 4'b0100);
      check("orphan_perr",  {3'b0, proto_err}, 4'd1);
      check("orphan_valid", {3'b0, flags_valid}, 4'd1);
      tick();
      tick();
      issue_only();
      retire("post_orphan", 1'b0, 2'b11, 32'd0, 32'hA000_0000, 32'd0, 1'b0, 4'b0110);
      check("sticky_perr", {3'b0, proto_err}, 4'd1);
      check("sticky_valid", {3'b0, flags_valid}, 4'd1);

      // Mid-cycle reset with a retire in flight
      issue_only();
      idle_inputs();
      alu_valid     = 1'b1;
      alu_set_flags = 1'b1;
      alu_op        = 2'b11;
      alu_b         = 32'hF000_0000;
      #2 rst_n = 1'b0;
      #1;
      check("async_flags", flags, 4'b0000);
      check("async_perr",  {3'b0, proto_err}, 4'd0);
      check("async_valid", {3'b0, flags_valid}, 4'd1);
      check("async_ready", {3'b0, issue_ready}, 4'd1);
      @(posedge clk);
      #1;
      check("rst_hold_flags", flags, 4'b0000);
      idle_inputs();
      #2 rst_n = 1'b1;

      // First edge after reset release is a normal edge
      issue_only();
      check("post_rst_valid", {3'b0, flags_valid}, 4'd0);
      retire("post_rst_sub", 1'b0, 2'b10, 32'd5, 32'd5, 32'd0, 1'b0, 4'b1100);
      check("post_rst_perr", {3'b0, proto_err}, 4'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
